// File: rtl/pdn_pkg.sv
// rtl/pdn_pkg.sv - flit layout, slot indices and flit helpers for pdn_inject_eject
package pdn_pkg;
  localparam int FLIT_W = 10;
  localparam int VLD    = 9;
  localparam int GOLD   = 8;
  localparam int DX_HI  = 7;
  localparam int DX_LO  = 6;
  localparam int DY_HI  = 5;
  localparam int DY_LO  = 4;
  localparam int PLD_HI = 3;
  localparam int PLD_LO = 0;

  localparam logic [1:0] N = 2'd0;
  localparam logic [1:0] S = 2'd1;
  localparam logic [1:0] W = 2'd2;
  localparam logic [1:0] E = 2'd3;

  function automatic logic is_local(input logic [FLIT_W-1:0] f,
                                    input logic [1:0] x,
                                    input logic [1:0] y);
    return f[VLD] && (f[DX_HI:DX_LO] == x) && (f[DY_HI:DY_LO] == y);
  endfunction

  // Locally generated flits always enter the network as non-golden.
  function automatic logic [FLIT_W-1:0] make_flit(input logic [7:0] body);
    logic [FLIT_W-1:0] f;
    f                = '0;
    f[VLD]           = 1'b1;
    f[GOLD]          = 1'b0;
    f[DX_HI:DX_LO]   = body[7:6];
    f[DY_HI:DY_LO]   = body[5:4];
    f[PLD_HI:PLD_LO] = body[3:0];
    return f;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, wrap-bit pointers, overflow/underflow requests ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_tdata,
  input  logic             in_tvalid,
  output logic             in_tready,
  output logic [WIDTH-1:0] out_tdata,
  output logic             out_tvalid,
  input  logic             out_tready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_tready  = !full;
  assign out_tvalid = (wr_ptr != rd_ptr);
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tready && out_tvalid;
  assign out_tdata  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_tdata;
  end
endmodule

// File: rtl/pdn_inject_eject.sv
// rtl/pdn_inject_eject.sv - local eject/inject stage feeding the pdn inputs through one register
// Optional RR_EJECT_EN: rotating eject priority instead of fixed N>S>W>E.
module pdn_inject_eject
  import pdn_pkg::*;
#(
  parameter logic [1:0] MY_X      = 2'd1,
  parameter logic [1:0] MY_Y      = 2'd2,
  parameter int         INJ_DEPTH = 4,
  parameter int         EJ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] link_n_in,
  input  logic [FLIT_W-1:0] link_s_in,
  input  logic [FLIT_W-1:0] link_w_in,
  input  logic [FLIT_W-1:0] link_e_in,
  output logic [FLIT_W-1:0] pdn_north,
  output logic [FLIT_W-1:0] pdn_south,
  output logic [FLIT_W-1:0] pdn_west,
  output logic [FLIT_W-1:0] pdn_east,
  input  logic              inj_valid,
  output logic              inj_ready,
  input  logic [7:0]        inj_data,
  output logic              ej_valid,
  input  logic              ej_ready,
  output logic [7:0]        ej_data
);
  logic [FLIT_W-1:0] slot_in  [4];
  logic [FLIT_W-1:0] slot_nxt [4];
  logic [FLIT_W-1:0] slot_q   [4];
  logic [1:0]        start_idx;
  logic [1:0]        idx;
  logic [1:0]        ej_idx;
  logic              ej_hit;
  logic              ej_room;
  logic              ej_push;
  logic [7:0]        ej_push_data;
  logic              inj_head_vld;
  logic [7:0]        inj_head;
  logic              inj_pop;

  assign slot_in[N] = link_n_in;
  assign slot_in[S] = link_s_in;
  assign slot_in[W] = link_w_in;
  assign slot_in[E] = link_e_in;

`ifdef RR_EJECT_EN
  logic [1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= N;
    else if (ej_hit) rr_ptr <= ej_idx + 2'd1;
  end

  assign start_idx = rr_ptr;
`else
  assign start_idx = N;
`endif

  always_comb begin
    ej_hit       = 1'b0;
    ej_idx       = start_idx;
    idx          = start_idx;
    inj_pop      = 1'b0;
    slot_nxt     = slot_in;
    for (int k = 0; k < 4; k++) begin
      idx = start_idx + 2'(k);
      if (!ej_hit && ej_room && is_local(slot_in[idx], MY_X, MY_Y)) begin
        ej_hit = 1'b1;
        ej_idx = idx;
      end
    end
    if (ej_hit) slot_nxt[ej_idx] = '0;
    ej_push      = ej_hit;
    ej_push_data = slot_in[ej_idx][DX_HI:PLD_LO];

    // A self-addressed injection uses the eject port only when no link flit claimed it.
    if (inj_head_vld) begin
      if (is_local(make_flit(inj_head), MY_X, MY_Y)) begin
        if (!ej_hit && ej_room) begin
          ej_push      = 1'b1;
          ej_push_data = inj_head;
          inj_pop      = 1'b1;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!inj_pop && !slot_nxt[k][VLD]) begin
            slot_nxt[k] = make_flit(inj_head);
            inj_pop     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) slot_q[k] <= slot_nxt[k];
    end
  end

  assign pdn_north = slot_q[N];
  assign pdn_south = slot_q[S];
  assign pdn_west  = slot_q[W];
  assign pdn_east  = slot_q[E];

  sync_fifo #(.WIDTH(8), .DEPTH(INJ_DEPTH)) u_inj_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (inj_data),
    .in_tvalid  (inj_valid),
    .in_tready  (inj_ready),
    .out_tdata  (inj_head),
    .out_tvalid (inj_head_vld),
    .out_tready (inj_pop)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(EJ_DEPTH)) u_ej_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tdata   (ej_push_data),
    .in_tvalid  (ej_push),
    .in_tready  (ej_room),
    .out_tdata  (ej_data),
    .out_tvalid (ej_valid),
    .out_tready (ej_ready)
  );
endmodule
